// File: rtl/lcd_digit_scan.sv
// Six-digit multiplexed 7-segment/LCD scanner: snapshots a frame of ASCII characters and
// drives each digit for TICKS_PER_DIGIT refresh ticks followed by one blank tick.
module lcd_digit_scan #(
    parameter int unsigned TICKS_PER_DIGIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic [7:0] upper10,
    input  logic [7:0] upper01,
    input  logic [7:0] lower1000,
    input  logic [7:0] lower0100,
    input  logic [7:0] lower0010,
    input  logic [7:0] lower0001,
    input  logic       point,
    input  logic       col,
    input  logic       AVS,
    input  logic       DAY,
    input  logic       MAX,
    input  logic       TIM,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] digit_en,
    output logic       col_out,
    output logic [3:0] ind,
    output logic       frame_done,
    output logic       bad_char
);

    typedef enum logic [1:0] {StIdle, StDrive, StBlank} state_e;

    localparam logic [3:0] LastTick = 4'(TICKS_PER_DIGIT - 1);

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [5:0][7:0] chars_in, chars_q, chars_d;
    logic            point_q, point_d;
    logic            col_q, col_d;
    logic [3:0]      ind_q, ind_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [5:0]      digit_en_q, digit_en_d;
    logic            frame_done_q, frame_done_d;
    logic            bad_char_q, bad_char_d;
    logic            snapshot;
    logic [7:0]      cur_char;
    logic [7:0]      cur_dec;

    // Returns {valid, g,f,e,d,c,b,a}.
    function automatic logic [7:0] decode_char(input logic [7:0] c);
        logic [7:0] r;
        case (c)
            8'h30:        r = {1'b1, 7'h3F};
            8'h31:        r = {1'b1, 7'h06};
            8'h32:        r = {1'b1, 7'h5B};
            8'h33:        r = {1'b1, 7'h4F};
            8'h34:        r = {1'b1, 7'h66};
            8'h35:        r = {1'b1, 7'h6D};
            8'h36:        r = {1'b1, 7'h7D};
            8'h37:        r = {1'b1, 7'h07};
            8'h38:        r = {1'b1, 7'h7F};
            8'h39:        r = {1'b1, 7'h6F};
            8'h2D:        r = {1'b1, 7'h40};
            8'h20, 8'h00: r = {1'b1, 7'h00};
            default:      r = {1'b0, 7'h00};
        endcase
        return r;
    endfunction

    assign chars_in = {lower0001, lower0010, lower0100, lower1000, upper01, upper10};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        snapshot     = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (scan_tick) begin
                    snapshot = 1'b1;
                    idx_d    = 3'd0;
                    cnt_d    = 4'd0;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                if (scan_tick) begin
                    if (cnt_q >= LastTick) begin
                        cnt_d   = 4'd0;
                        state_d = StBlank;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StBlank: begin
                if (scan_tick) begin
                    cnt_d   = 4'd0;
                    state_d = StDrive;
                    if (idx_q == 3'd5) begin
                        idx_d        = 3'd0;
                        snapshot     = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        chars_d = snapshot ? chars_in : chars_q;
        point_d = snapshot ? point : point_q;
        col_d   = snapshot ? col : col_q;
        ind_d   = snapshot ? {AVS, DAY, MAX, TIM} : ind_q;
    end

    // Outputs are computed from next-state values so they register alongside the transition.
    always_comb begin
        cur_char   = chars_d[idx_d];
        cur_dec    = decode_char(cur_char);
        seg_d      = 7'h00;
        dp_d       = 1'b0;
        digit_en_d = 6'h00;
        bad_char_d = bad_char_q;
        if (state_d == StDrive) begin
            seg_d      = cur_dec[6:0];
            digit_en_d = 6'b000001 << idx_d;
            dp_d       = point_d && (idx_d == 3'd4);
            bad_char_d = bad_char_q | ~cur_dec[7];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= 3'd0;
            cnt_q        <= 4'd0;
            chars_q      <= '0;
            point_q      <= 1'b0;
            col_q        <= 1'b0;
            ind_q        <= 4'h0;
            seg_q        <= 7'h00;
            dp_q         <= 1'b0;
            digit_en_q   <= 6'h00;
            frame_done_q <= 1'b0;
            bad_char_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            chars_q      <= chars_d;
            point_q      <= point_d;
            col_q        <= col_d;
            ind_q        <= ind_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
            bad_char_q   <= bad_char_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_en   = digit_en_q;
    assign col_out    = col_q;
    assign ind        = ind_q;
    assign frame_done = frame_done_q;
    assign bad_char   = bad_char_q;

endmodule

// File: tb/tb_lcd_digit_scan.sv
// Directed bench for lcd_digit_scan: a TICKS=4 instance with sparse ticks and a TICKS=1
// instance with scan_tick held high.
module tb_lcd_digit_scan;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       scan_tick = 1'b0;
    logic       scan_tick1 = 1'b0;
    logic [7:0] upper10 = 8'h00, upper01 = 8'h00, lower1000 = 8'h00;
    logic [7:0] lower0100 = 8'h00, lower0010 = 8'h00, lower0001 = 8'h00;
    logic       point = 1'b0, col = 1'b0, AVS = 1'b0, DAY = 1'b0, MAX = 1'b0, TIM = 1'b0;

    logic [6:0] seg, seg1;
    logic       dp, dp1;
    logic [5:0] digit_en, digit_en1;
    logic       col_out, col_out1;
    logic [3:0] ind, ind1;
    logic       frame_done, frame_done1;
    logic       bad_char, bad_char1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_tab [6] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h00};

    lcd_digit_scan #(.TICKS_PER_DIGIT(4)) dut (
        .clock(clock), .reset(reset), .scan_tick(scan_tick),
        .upper10(upper10), .upper01(upper01), .lower1000(lower1000),
        .lower0100(lower0100), .lower0010(lower0010), .lower0001(lower0001),
        .point(point), .col(col), .AVS(AVS), .DAY(DAY), .MAX(MAX), .TIM(TIM),
        .seg(seg), .dp(dp), .digit_en(digit_en), .col_out(col_out), .ind(ind),
        .frame_done(frame_done), .bad_char(bad_char)
    );

    lcd_digit_scan #(.TICKS_PER_DIGIT(1)) dut1 (
        .clock(clock), .reset(reset), .scan_tick(scan_tick1),
        .upper10(upper10), .upper01(upper01), .lower1000(lower1000),
        .lower0100(lower0100), .lower0010(lower0010), .lower0001(lower0001),
        .point(point), .col(col), .AVS(AVS), .DAY(DAY), .MAX(MAX), .TIM(TIM),
        .seg(seg1), .dp(dp1), .digit_en(digit_en1), .col_out(col_out1), .ind(ind1),
        .frame_done(frame_done1), .bad_char(bad_char1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Two idle clocks, then one clock with scan_tick high; outputs sampled after that edge.
    task automatic tick_once();
        step();
        step();
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    initial begin
        logic [5:0] en_e;
        logic [6:0] seg_e;
        logic       dp_e;

        // Reset wins over a simultaneous tick.
        reset = 1'b1;
        scan_tick = 1'b1;
        step();
        step();
        reset = 1'b0;
        scan_tick = 1'b0;
        check("rst_en", digit_en, 6'h00);
        check("rst_seg", seg, 7'h00);
        check("rst_dp", dp, 1'b0);
        check("rst_col", col_out, 1'b0);
        check("rst_ind", ind, 4'h0);
        check("rst_fd", frame_done, 1'b0);
        check("rst_bad", bad_char, 1'b0);
        step();
        step();
        check("idle_en", digit_en, 6'h00);

        // Frame 1: "12345 " with point, colon and TIM.
        upper10 = 8'h31; upper01 = 8'h32; lower1000 = 8'h33;
        lower0100 = 8'h34; lower0010 = 8'h35; lower0001 = 8'h20;
        point = 1'b1; col = 1'b1; TIM = 1'b1;
        tick_once();
        check("f1_en0", digit_en, 6'h01);
        check("f1_seg0", seg, 7'h06);
        check("f1_col0", col_out, 1'b1);
        check("f1_ind0", ind, 4'b0001);
        for (int t = 1; t < 30; t++) begin
            if (t == 11) begin
                upper10 = 8'h39;
                col = 1'b0;
            end
            tick_once();
            if (t % 5 == 4) begin
                en_e = 6'h00; seg_e = 7'h00; dp_e = 1'b0;
            end else begin
                en_e = 6'b000001 << (t / 5);
                seg_e = seg_tab[t / 5];
                dp_e = (t / 5 == 4);
            end
            check("f1_en", digit_en, en_e);
            check("f1_seg", seg, seg_e);
            check("f1_dp", dp, dp_e);
            check("f1_col", col_out, 1'b1);
            check("f1_ind", ind, 4'b0001);
            check("f1_fd", frame_done, 1'b0);
        end
        check("f1_bad", bad_char, 1'b0);

        // Tick 30 closes the frame and snapshots the changed inputs.
        tick_once();
        check("f2_fd", frame_done, 1'b1);
        check("f2_en0", digit_en, 6'h01);
        check("f2_seg0", seg, 7'h6F);
        check("f2_col", col_out, 1'b0);
        check("f2_ind", ind, 4'b0001);
        step();
        check("f2_fd_pulse", frame_done, 1'b0);

        // Undecodable 'A' on lower0001 from frame 3 on.
        lower0001 = 8'h41;
        run_ticks(30);
        run_ticks(24);
        check("f3_bad_pre", bad_char, 1'b0);
        tick_once();
        check("f3_en5", digit_en, 6'h20);
        check("f3_seg5", seg, 7'h00);
        check("f3_bad", bad_char, 1'b1);
        lower0001 = 8'h36;
        run_ticks(30);
        check("f4_en5", digit_en, 6'h20);
        check("f4_seg5", seg, 7'h7D);
        check("f4_bad_sticky", bad_char, 1'b1);

        // Reset with a tick during digit 3 DRIVE.
        run_ticks(5);
        run_ticks(15);
        check("f5_en3", digit_en, 6'h08);
        reset = 1'b1;
        scan_tick = 1'b1;
        step();
        reset = 1'b0;
        scan_tick = 1'b0;
        check("mid_rst_en", digit_en, 6'h00);
        check("mid_rst_seg", seg, 7'h00);
        check("mid_rst_fd", frame_done, 1'b0);
        check("mid_rst_bad", bad_char, 1'b0);
        check("mid_rst_ind", ind, 4'h0);
        step();
        step();
        check("post_rst_idle", digit_en, 6'h00);
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        check("restart_en", digit_en, 6'h01);
        check("restart_seg", seg, 7'h6F);

        // TICKS=1 with scan_tick held high.
        reset = 1'b1;
        step();
        reset = 1'b0;
        scan_tick1 = 1'b1;
        for (int s = 1; s <= 25; s++) begin
            step();
            en_e = ((s - 1) % 2 == 0) ? (6'b000001 << (((s - 1) / 2) % 6)) : 6'h00;
            check("t1_en", digit_en1, en_e);
            check("t1_fd", frame_done1, (s > 1) && ((s - 1) % 12 == 0));
            if (s == 1) begin
                check("t1_seg0", seg1, 7'h6F);
                check("t1_ind", ind1, 4'b0001);
                check("t1_col", col_out1, 1'b0);
            end
            if (s == 9) check("t1_dp4", dp1, 1'b1);
        end
        scan_tick1 = 1'b0;
        check("t1_bad", bad_char1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
